rv_seq_check_sink: RTL and testbench
====================================

# rv_seq_check_sink

Ready/valid stream consumer that terminates a stream produced by the team's ready/valid sources. It applies a programmable backpressure pattern on `inReady_o` and checks that accepted words form a strictly incrementing sequence. It reports transfer and error counts and stops accepting after a configurable number of words. It sits at the far end of a ready/valid link in simulation benches and in hardware self-test paths.

## Interface

Parameters:

- `NBITS`, 32: data width.
- `CNTBITS`, 16: width of the transfer and error counters.
- `START_VAL`, 0: first expected data value (NBITS wide).
- `READY_MASK`, 16'hFFFF: backpressure pattern. Bit *k* = 1 allows ready in phase *k*.
- `NWORDS`, 0: number of words to accept before halting. 0 = unlimited.

Ports:

- `clk_i`, in, 1: clock. All state changes on the rising edge.
- `rstn_i`, in, 1: reset, asynchronous, active-low.
- `inReady_o`, out, 1: sink ready.
- `inValid_i`, in, 1: source valid.
- `inData_i`, in, NBITS: source data.
- `rxCount_o`, out, CNTBITS: accepted words, saturating.
- `errCount_o`, out, CNTBITS: sequence mismatches, saturating.
- `errFlag_o`, out, 1: sticky; set on the first mismatch.
- `firstErrData_o`, out, NBITS: data of the first mismatching word.
- `protoErr_o`, out, 1: sticky protocol violation (see Configuration).
- `done_o`, out, 1: NWORDS reached.

## Operation

- State machine: IDLE -> RUN -> DONE.
  - Reset enters IDLE.
  - IDLE -> RUN unconditionally on the first clock after reset release.
  - RUN -> DONE on the transfer that makes `rxCount` equal NWORDS, when NWORDS != 0.
  - DONE is terminal until reset.
- `phase`: 4-bit free-running counter. Reset value 0. Increments every cycle in every state and wraps 15 -> 0.
- `inReady_o` = (state == RUN) & READY_MASK[phase]. It is a pure function of registers, with no combinational path from `inValid_i`.
- Transfer = `inReady_o` & `inValid_i`. On a transfer:
  - `rxCount` increments, saturating at 2^CNTBITS-1.
  - If `inData_i` != `expected`: `errCount` increments (saturating). If `errFlag` is clear, `firstErrData` <= `inData_i` and `errFlag` <= 1.
  - `expected` <= `inData_i` + 1, modulo 2^NBITS. The checker resynchronises after a mismatch, so a single bad word costs exactly one error.
- `expected` resets to START_VAL.
- Data is ignored while `inValid_i` = 0 or `inReady_o` = 0. X on ignored data has no effect.
- Reset values: `inReady_o` 0, all counters 0, `errFlag_o` 0, `firstErrData_o` 0, `protoErr_o` 0, `done_o` 0.
- Reset asserted mid-transfer: all state clears immediately (asynchronous). A word presented in that cycle is not counted.

## Timing

- Output latency: all status outputs update on the clock edge that completes the transfer, so they are visible one cycle after the handshake cycle.
- Earliest acceptance: the first cycle in which `inReady_o` can be 1 is the second rising edge after `rstn_i` deasserts.
- `done_o` rises on the same edge as the final `rxCount` update. `inReady_o` is 0 from that edge on.
- Maximum throughput: with READY_MASK = all ones, one word per cycle.
- Wrap boundary: `expected` = 2^NBITS-1 followed by data 0 is a match. The counters saturate rather than wrap.

## Configuration

- `RV_SEQ_CHECK_PROTOCOL_EN` defined: the protocol checker is compiled in. `protoErr_o` is set (sticky) when either rule is broken in a cycle where the previous cycle had `inValid_i` = 1 and `inReady_o` = 0:
  - `inValid_i` drops to 0 (valid retraction), or
  - `inData_i` differs from the previous cycle's data.
  - Checker cost: one NBITS data register plus one stall flag.
- Undefined: `protoErr_o` is tied to 0 and no extra registers are generated.

## Test plan

1. Source sends 0..99 continuously, READY_MASK = 16'hFFFF, NWORDS = 0 -> `rxCount_o` = 100, `errCount_o` = 0, `errFlag_o` = 0, one word per cycle.
2. READY_MASK = 16'h00FF, source always valid with 0,1,2,... -> `inReady_o` high for phases 0-7 only. After 32 cycles in RUN, `rxCount_o` = 16 and there are no errors.
3. Sequence 0,1,2,7,8,3 -> `errCount_o` = 2 (at 7 and at 3), `firstErrData_o` = 7, `errFlag_o` = 1.
4. NWORDS = 10, source offers 20 words -> `done_o` = 1 after the 10th transfer, `inReady_o` stays 0, `rxCount_o` = 10.
5. With `RV_SEQ_CHECK_PROTOCOL_EN` defined and READY_MASK = 16'h0000, the source drops `inValid_i` after one stalled cycle -> `protoErr_o` = 1 next cycle. With the macro undefined the same stimulus gives `protoErr_o` = 0.
6. START_VAL = 32'hFFFFFFFE, data FFFFFFFE, FFFFFFFF, 0, 1 -> no errors. Asserting `rstn_i` low mid-stream clears all outputs asynchronously, and the checker restarts expecting START_VAL.

Source files
------------

// File: rtl/rv_seq_check_sink_if.sv
// Ready/valid stream link carrying NBITS-wide words from a source (master)
// to a sink (slave).
interface rv_seq_check_sink_if #(
  parameter int unsigned NBITS = 32
);
  logic             inReady;
  logic             inValid;
  logic [NBITS-1:0] inData;

  modport master (
    output inValid,
    output inData,
    input  inReady
  );

  modport slave (
    input  inValid,
    input  inData,
    output inReady
  );
endinterface

// File: rtl/rv_seq_check_sink.sv
// Ready/valid sink with a programmable backpressure pattern and an incrementing-sequence checker.
// Define RV_SEQ_CHECK_PROTOCOL_EN to compile in the valid-retraction / data-stability checker.
module rv_seq_check_sink #(
  parameter int unsigned      NBITS      = 32,
  parameter int unsigned      CNTBITS    = 16,
  parameter logic [NBITS-1:0] START_VAL  = '0,
  parameter logic [15:0]      READY_MASK = 16'hFFFF,
  parameter int unsigned      NWORDS     = 0
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  rv_seq_check_sink_if.slave   in_if,
  output logic [CNTBITS-1:0]   rxCount_o,
  output logic [CNTBITS-1:0]   errCount_o,
  output logic                 errFlag_o,
  output logic [NBITS-1:0]     firstErrData_o,
  output logic                 protoErr_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam bit               LIMIT_EN = (NWORDS != 0);
  localparam logic [CNTBITS-1:0] NWORDS_C = CNTBITS'(NWORDS);

  state_t               state_q, state_d;
  logic [3:0]           phase_q, phase_d;
  logic [CNTBITS-1:0]   rx_count_q, rx_count_d;
  logic [CNTBITS-1:0]   err_count_q, err_count_d;
  logic                 err_flag_q, err_flag_d;
  logic [NBITS-1:0]     first_err_q, first_err_d;
  logic [NBITS-1:0]     expected_q, expected_d;
  logic                 in_ready;
  logic                 xfer;

  // Ready depends only on registered state, never on inValid.
  assign in_ready      = (state_q == S_RUN) && READY_MASK[phase_q];
  assign in_if.inReady = in_ready;
  assign xfer          = in_ready && in_if.inValid;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    rx_count_d  = rx_count_q;
    err_count_d = err_count_q;
    err_flag_d  = err_flag_q;
    first_err_d = first_err_q;
    expected_d  = expected_q;
    phase_d     = phase_q + 4'd1;

    if (xfer) begin
      if (rx_count_q != '1) rx_count_d = rx_count_q + CNTBITS'(1);
      // Resynchronise on every accepted word so one bad word costs one error.
      expected_d = in_if.inData + NBITS'(1);
      if (in_if.inData != expected_q) begin
        if (err_count_q != '1) err_count_d = err_count_q + CNTBITS'(1);
        if (!err_flag_q) begin
          err_flag_d  = 1'b1;
          first_err_d = in_if.inData;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        if (LIMIT_EN && xfer && (rx_count_d == NWORDS_C)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      phase_q     <= 4'd0;
      rx_count_q  <= '0;
      err_count_q <= '0;
      err_flag_q  <= 1'b0;
      first_err_q <= '0;
      expected_q  <= START_VAL;
    end else begin
      phase_q     <= phase_d;
      rx_count_q  <= rx_count_d;
      err_count_q <= err_count_d;
      err_flag_q  <= err_flag_d;
      first_err_q <= first_err_d;
      expected_q  <= expected_d;
    end
  end

  assign rxCount_o      = rx_count_q;
  assign errCount_o     = err_count_q;
  assign errFlag_o      = err_flag_q;
  assign firstErrData_o = first_err_q;
  assign done_o         = (state_q == S_DONE);

`ifdef RV_SEQ_CHECK_PROTOCOL_EN
  // A stalled word (valid & !ready) must stay valid and unchanged next cycle.
  logic             stall_q;
  logic [NBITS-1:0] held_data_q;
  logic             proto_err_q;
  logic             proto_violation;

  assign proto_violation = stall_q && (!in_if.inValid || (in_if.inData != held_data_q));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stall_q     <= 1'b0;
      // NOTE: held_data_q is only read while stall_q is set; it is reset anyway to keep X out of the compare.
      held_data_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      stall_q     <= in_if.inValid && !in_ready;
      held_data_q <= in_if.inData;
      if (proto_violation) proto_err_q <= 1'b1;
    end
  end

  assign protoErr_o = proto_err_q;
`else
  assign protoErr_o = 1'b0;
`endif

endmodule

// File: tb/tb_rv_seq_check_sink.sv
// Directed self-checking bench for rv_seq_check_sink: one DUT instance per
// parameter set, one task per scenario, inline comparisons.
module tb_rv_seq_check_sink;

`ifdef RV_SEQ_CHECK_PROTOCOL_EN
  localparam logic PROTO_EN = 1'b1;
`else
  localparam logic PROTO_EN = 1'b0;
`endif

  logic clk;
  logic rstn;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a: defaults; b: half-duty mask; c: NWORDS=10; d: never ready; e: wrap + 3-bit counters
  rv_seq_check_sink_if #(.NBITS(32)) if_a ();
  rv_seq_check_sink_if #(.NBITS(32)) if_b ();
  rv_seq_check_sink_if #(.NBITS(32)) if_c ();
  rv_seq_check_sink_if #(.NBITS(32)) if_d ();
  rv_seq_check_sink_if #(.NBITS(32)) if_e ();

  logic [15:0] rx_a, err_a, rx_b, err_b, rx_c, err_c, rx_d, err_d;
  logic [2:0]  rx_e, err_e;
  logic        flag_a, flag_b, flag_c, flag_d, flag_e;
  logic [31:0] first_a, first_b, first_c, first_d, first_e;
  logic        proto_a, proto_b, proto_c, proto_d, proto_e;
  logic        done_a, done_b, done_c, done_d, done_e;

  rv_seq_check_sink #(.NBITS(32), .CNTBITS(16)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .in_if(if_a.slave),
    .rxCount_o(rx_a), .errCount_o(err_a), .errFlag_o(flag_a),
    .firstErrData_o(first_a), .protoErr_o(proto_a), .done_o(done_a));

  rv_seq_check_sink #(.NBITS(32), .CNTBITS(16), .READY_MASK(16'h00FF)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .in_if(if_b.slave),
    .rxCount_o(rx_b), .errCount_o(err_b), .errFlag_o(flag_b),
    .firstErrData_o(first_b), .protoErr_o(proto_b), .done_o(done_b));

  rv_seq_check_sink #(.NBITS(32), .CNTBITS(16), .NWORDS(10)) dut_c (
    .clk_i(clk), .rstn_i(rstn), .in_if(if_c.slave),
    .rxCount_o(rx_c), .errCount_o(err_c), .errFlag_o(flag_c),
    .firstErrData_o(first_c), .protoErr_o(proto_c), .done_o(done_c));

  rv_seq_check_sink #(.NBITS(32), .CNTBITS(16), .READY_MASK(16'h0000)) dut_d (
    .clk_i(clk), .rstn_i(rstn), .in_if(if_d.slave),
    .rxCount_o(rx_d), .errCount_o(err_d), .errFlag_o(flag_d),
    .firstErrData_o(first_d), .protoErr_o(proto_d), .done_o(done_d));

  rv_seq_check_sink #(.NBITS(32), .CNTBITS(3), .START_VAL(32'hFFFF_FFFE)) dut_e (
    .clk_i(clk), .rstn_i(rstn), .in_if(if_e.slave),
    .rxCount_o(rx_e), .errCount_o(err_e), .errFlag_o(flag_e),
    .firstErrData_o(first_e), .protoErr_o(proto_e), .done_o(done_e));

  // Idles every source, holds reset for two cycles, releases on a falling edge.
  task automatic reset_release();
    @(negedge clk);
    rstn = 1'b0;
    if_a.inValid = 1'b0; if_a.inData = '0;
    if_b.inValid = 1'b0; if_b.inData = '0;
    if_c.inValid = 1'b0; if_c.inData = '0;
    if_d.inValid = 1'b0; if_d.inData = '0;
    if_e.inValid = 1'b0; if_e.inData = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_checks++; if (if_a.inReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b expected 0", if_a.inReady); end
    n_checks++; if (rx_a !== 16'd0) begin n_fail++; $display("FAIL reset_rx: got %0d expected 0", rx_a); end
    n_checks++; if (err_a !== 16'd0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", err_a); end
    n_checks++; if (flag_a !== 1'b0) begin n_fail++; $display("FAIL reset_flag: got %0b expected 0", flag_a); end
    n_checks++; if (first_a !== 32'd0) begin n_fail++; $display("FAIL reset_first: got %0h expected 0", first_a); end
    n_checks++; if (proto_a !== 1'b0) begin n_fail++; $display("FAIL reset_proto: got %0b expected 0", proto_a); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done_a); end
    reset_release();
    // Still IDLE until the first edge after release.
    n_checks++; if (if_a.inReady !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %0b expected 0", if_a.inReady); end
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (if_a.inReady !== 1'b1) begin n_fail++; $display("FAIL first_ready: got %0b expected 1", if_a.inReady); end
  endtask

  task automatic test_stream();
    int stalls = 0;
    reset_release();
    @(posedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if_a.inValid = 1'b1;
      if_a.inData  = 32'(i);
      if (if_a.inReady !== 1'b1) stalls++;
      @(posedge clk);
    end
    @(negedge clk);
    if_a.inValid = 1'b0;
    if_a.inData  = 'x;
    n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL stream_stalls: got %0d expected 0", stalls); end
    n_checks++; if (rx_a !== 16'd100) begin n_fail++; $display("FAIL stream_rx: got %0d expected 100", rx_a); end
    n_checks++; if (err_a !== 16'd0) begin n_fail++; $display("FAIL stream_err: got %0d expected 0", err_a); end
    n_checks++; if (flag_a !== 1'b0) begin n_fail++; $display("FAIL stream_flag: got %0b expected 0", flag_a); end
    // Ignored X data must not disturb anything.
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (rx_a !== 16'd100 || err_a !== 16'd0) begin n_fail++; $display("FAIL stream_idle_x: got rx %0d err %0d expected rx 100 err 0", rx_a, err_a); end
    if_a.inData = '0;
  endtask

  task automatic test_backpressure();
    int edges = 1;
    int word = 0;
    int ready_bad = 0;
    logic hs;
    reset_release();
    @(posedge clk);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if_b.inValid = 1'b1;
      if_b.inData  = 32'(word);
      if (if_b.inReady !== ((edges % 16) < 8)) ready_bad++;
      hs = if_b.inReady;
      @(posedge clk);
      edges++;
      if (hs) word++;
    end
    @(negedge clk);
    if_b.inValid = 1'b0;
    n_checks++; if (ready_bad != 0) begin n_fail++; $display("FAIL bp_ready_pattern: got %0d wrong cycles expected 0", ready_bad); end
    n_checks++; if (rx_b !== 16'd16) begin n_fail++; $display("FAIL bp_rx: got %0d expected 16", rx_b); end
    n_checks++; if (err_b !== 16'd0) begin n_fail++; $display("FAIL bp_err: got %0d expected 0", err_b); end
  endtask

  task automatic test_errors();
    logic [31:0] vals [6] = '{32'd0, 32'd1, 32'd2, 32'd7, 32'd8, 32'd3};
    int flag_bad = 0;
    reset_release();
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      // Flag becomes visible the cycle after the word 7 handshake.
      if (flag_a !== (i > 3)) flag_bad++;
      if (i < 6) begin
        if_a.inValid = 1'b1;
        if_a.inData  = vals[i];
        @(posedge clk);
      end else begin
        if_a.inValid = 1'b0;
      end
    end
    n_checks++; if (flag_bad != 0) begin n_fail++; $display("FAIL err_flag_timing: got %0d wrong cycles expected 0", flag_bad); end
    n_checks++; if (err_a !== 16'd2) begin n_fail++; $display("FAIL err_count: got %0d expected 2", err_a); end
    n_checks++; if (first_a !== 32'd7) begin n_fail++; $display("FAIL err_first: got %0h expected 7", first_a); end
    n_checks++; if (flag_a !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %0b expected 1", flag_a); end
    n_checks++; if (rx_a !== 16'd6) begin n_fail++; $display("FAIL err_rx: got %0d expected 6", rx_a); end
  endtask

  task automatic test_nwords();
    int word = 0;
    int done_bad = 0;
    int ready_after_done = 0;
    logic hs;
    reset_release();
    @(posedge clk);
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done_c !== (word >= 10)) done_bad++;
      if (word >= 10 && if_c.inReady !== 1'b0) ready_after_done++;
      if_c.inValid = (word < 20);
      if_c.inData  = 32'(word);
      hs = if_c.inValid && if_c.inReady;
      @(posedge clk);
      if (hs) word++;
    end
    @(negedge clk);
    if_c.inValid = 1'b0;
    n_checks++; if (done_bad != 0) begin n_fail++; $display("FAIL nw_done_timing: got %0d wrong cycles expected 0", done_bad); end
    n_checks++; if (ready_after_done != 0) begin n_fail++; $display("FAIL nw_ready_after_done: got %0d cycles expected 0", ready_after_done); end
    n_checks++; if (rx_c !== 16'd10) begin n_fail++; $display("FAIL nw_rx: got %0d expected 10", rx_c); end
    n_checks++; if (done_c !== 1'b1) begin n_fail++; $display("FAIL nw_done: got %0b expected 1", done_c); end
    n_checks++; if (err_c !== 16'd0) begin n_fail++; $display("FAIL nw_err: got %0d expected 0", err_c); end
  endtask

  task automatic test_protocol();
    // Valid retraction after one stalled cycle.
    reset_release();
    @(posedge clk);
    @(negedge clk);
    if_d.inValid = 1'b1;
    if_d.inData  = 32'd5;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (proto_d !== 1'b0) begin n_fail++; $display("FAIL proto_before_drop: got %0b expected 0", proto_d); end
    if_d.inValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (proto_d !== PROTO_EN) begin n_fail++; $display("FAIL proto_drop: got %0b expected %0b", proto_d, PROTO_EN); end

    // A steadily held stalled word is legal.
    reset_release();
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if_d.inValid = 1'b1;
      if_d.inData  = 32'hA5;
      @(posedge clk);
    end
    @(negedge clk);
    n_checks++; if (proto_d !== 1'b0) begin n_fail++; $display("FAIL proto_hold: got %0b expected 0", proto_d); end

    // Data change while stalled.
    if_d.inData = 32'hA6;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (proto_d !== PROTO_EN) begin n_fail++; $display("FAIL proto_data_change: got %0b expected %0b", proto_d, PROTO_EN); end
    n_checks++; if (rx_d !== 16'd0) begin n_fail++; $display("FAIL proto_rx: got %0d expected 0", rx_d); end
    if_d.inValid = 1'b0;
  endtask

  task automatic test_wrap_reset();
    logic [31:0] vals [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    reset_release();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if_e.inValid = 1'b1;
      if_e.inData  = vals[i];
      @(posedge clk);
    end
    @(negedge clk);
    if_e.inValid = 1'b0;
    n_checks++; if (err_e !== 3'd0) begin n_fail++; $display("FAIL wrap_err: got %0d expected 0", err_e); end
    n_checks++; if (rx_e !== 3'd4) begin n_fail++; $display("FAIL wrap_rx: got %0d expected 4", rx_e); end

    // Nine words of constant 100: each one mismatches; both 3-bit counters saturate at 7.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if_e.inValid = 1'b1;
      if_e.inData  = 32'd100;
      @(posedge clk);
    end
    @(negedge clk);
    n_checks++; if (rx_e !== 3'd7) begin n_fail++; $display("FAIL sat_rx: got %0d expected 7", rx_e); end
    n_checks++; if (err_e !== 3'd7) begin n_fail++; $display("FAIL sat_err: got %0d expected 7", err_e); end
    n_checks++; if (first_e !== 32'd100) begin n_fail++; $display("FAIL sat_first: got %0h expected 64", first_e); end

    // Reset asserted mid-transfer clears immediately and the word is not counted.
    if_e.inValid = 1'b1;
    if_e.inData  = 32'hFFFF_FFFE;
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (rx_e !== 3'd0 || err_e !== 3'd0 || flag_e !== 1'b0 || first_e !== 32'd0 || if_e.inReady !== 1'b0)
      begin n_fail++; $display("FAIL async_clear: got rx %0d err %0d flag %0b first %0h ready %0b expected all 0", rx_e, err_e, flag_e, first_e, if_e.inReady); end
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (rx_e !== 3'd0) begin n_fail++; $display("FAIL reset_no_count: got %0d expected 0", rx_e); end
    rstn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if_e.inValid = 1'b0;
    n_checks++; if (rx_e !== 3'd1 || err_e !== 3'd0) begin n_fail++; $display("FAIL restart_start_val: got rx %0d err %0d expected rx 1 err 0", rx_e, err_e); end
  endtask

  initial begin
    rstn = 1'b0;
    if_a.inValid = 1'b0; if_a.inData = '0;
    if_b.inValid = 1'b0; if_b.inData = '0;
    if_c.inValid = 1'b0; if_c.inData = '0;
    if_d.inValid = 1'b0; if_d.inData = '0;
    if_e.inValid = 1'b0; if_e.inData = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_errors();
    test_nwords();
    test_protocol();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
